hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline sequencer for the five-stage MIPS core. It drives the write-enable (`*_W`) and synchronous-flush (`*_RST`) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves memory waits, load-use hazards, EX-stage redirects and HALT drain. It also keeps saturating cycle, stall and flush performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN, mem_dWEN  in  1 each  MEM-stage load/store pending
- mem_halt  in  1  HALT instruction is in the MEM stage
- ex_dREN  in  1  EX-stage instruction is a load
- ex_WEN  in  1  EX-stage instruction writes the register file
- ex_wsel  in  5  EX-stage destination register
- id_rsel1, id_rsel2  in  5 each  ID-stage source registers
- id_use_rs, id_use_rt  in  1 each  ID-stage instruction reads rsel1 / rsel2
- ex_redirect  in  1  taken branch or jump resolved in EX
- pc_W  out  1  PC load enable
- ifid_W, idex_W, exmem_W, memwb_W  out  1 each  register advance
- ifid_RST, idex_RST, exmem_RST, memwb_RST  out  1 each  register flush (bubble)
- halt  out  1  core halted, sticky until reset
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, DRAIN, HALTED. The state register is the only control state; all control outputs are combinational from state and inputs.
- For each register, `_W` and `_RST` are never both 1. If `_RST` is 1, `_W` is 0.
- In RUN, evaluate the following in priority order. The first match applies. Any enable or flush not listed is 0.
  1. **mem_stall** = (mem_dREN | mem_dWEN) & !dhit.
     - memwb_RST=1; all `_W`=0.
     - stall_cnt++.
  2. **mem_halt**:
     - ifid_RST=idex_RST=exmem_RST=1 (squash younger instructions); memwb_W=1; pc_W=0.
     - Next state DRAIN.
  3. **ex_redirect**:
     - pc_W=1, ifid_RST=1, idex_RST=1, exmem_W=1, memwb_W=1.
     - ihit is ignored; the in-flight fetch is abandoned.
     - flush_cnt++.
  4. **load_use** = ex_dREN & ex_WEN & (ex_wsel≠0) & ((id_use_rs & id_rsel1==ex_wsel) | (id_use_rt & id_rsel2==ex_wsel)).
     - pc_W=0, ifid_W=0, idex_RST=1, exmem_W=1, memwb_W=1.
     - stall_cnt++.
  5. **!ihit**:
     - pc_W=0, ifid_RST=1, idex_W=exmem_W=memwb_W=1.
     - stall_cnt++.
  6. **Otherwise**: pc_W and all four `_W`=1.
- In DRAIN: memwb_RST=1, all `_W`=0, pc_W=0. Next state HALTED unconditionally. During this cycle the HALT instruction is in WB.
- In HALTED:
  - All `_W`=0 and all `_RST`=0.
  - halt=1.
  - Stays in HALTED until nRST.
- Counters:
  - cycle_cnt increments every cycle in RUN or DRAIN.
  - All counters saturate at 2^CNT_W−1 and never wrap.
  - Counters hold in HALTED.
  - At most one of stall_cnt / flush_cnt increments per cycle.

## Timing
- While nRST is low:
  - State is RUN.
  - All `_W`, `_RST` and halt are 0.
  - All counters are 0.
- Reset has priority over everything. Asserting nRST mid-stall or mid-DRAIN returns to RUN immediately, and the counters clear.
- Control outputs have zero latency: they are valid in the same cycle as their inputs, and the pipeline registers act on the next CLK edge.
- State and counter updates occur on the CLK rising edge.
- A mem_stall holds the whole pipeline frozen, so ex_redirect and mem_halt remain stable until dhit. No redirect is lost.
- HALT latency: mem_halt seen in cycle N; DRAIN in N+1; halt=1 from N+2.
- A load-use stall lasts exactly one cycle unless a higher-priority condition overlaps it.
- ex_wsel=0 never causes a load-use stall.

## Test plan
- **Reset, then a clean stream.** Release nRST; ihit=1, no hazards, 10 cycles.
  - Expect pc_W and all `_W`=1 every cycle, cycle_cnt=10, stall_cnt=0, flush_cnt=0.
- **Load-use.** ex_dREN=1, ex_WEN=1, ex_wsel=5, id_use_rt=1, id_rsel2=5.
  - Expect pc_W=0, ifid_W=0, idex_RST=1 for one cycle, and stall_cnt increments by 1.
  - Repeat with ex_wsel=0: expect no stall.
- **Memory wait.** mem_dREN=1, dhit=0 for 3 cycles, then dhit=1.
  - Expect all `_W`=0 and memwb_RST=1 for 3 cycles, then a normal advance; stall_cnt=3.
- **Redirect overlapping a memory stall.** ex_redirect=1 with a pending data access and dhit=0 for 2 cycles.
  - Expect a freeze for 2 cycles, then pc_W=1, ifid_RST=1, idex_RST=1 in the dhit cycle; flush_cnt=1.
- **Halt precedence and drain.** mem_halt=1 together with ex_redirect=1.
  - Expect squash of ifid/idex/exmem and pc_W=0, then DRAIN with memwb_RST=1, then halt=1 held.
  - Counters freeze in HALTED.
  - Pulsing nRST low clears halt and all counters.
- **Saturation.** Run with CNT_W=4 and a continuous !ihit for 20 cycles.
  - Expect stall_cnt=15 and cycle_cnt=15, held at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard sequencer and the datapath.
// The master side is the sequencer. It takes hit and hazard status and
// drives the per-register advance/flush controls and the perf counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Status from the datapath
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_halt;
  logic             ex_dREN;
  logic             ex_WEN;
  logic [4:0]       ex_wsel;
  logic [4:0]       id_rsel1;
  logic [4:0]       id_rsel2;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_redirect;

  // Controls back to the datapath
  logic             pc_W;
  logic             ifid_W;
  logic             idex_W;
  logic             exmem_W;
  logic             memwb_W;
  logic             ifid_RST;
  logic             idex_RST;
  logic             exmem_RST;
  logic             memwb_RST;
  logic             halt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_WEN,
           ex_wsel, id_rsel1, id_rsel2, id_use_rs, id_use_rt, ex_redirect,
    output pc_W, ifid_W, idex_W, exmem_W, memwb_W,
           ifid_RST, idex_RST, exmem_RST, memwb_RST, halt,
           cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_WEN,
           ex_wsel, id_rsel1, id_rsel2, id_use_rs, id_use_rt, ex_redirect,
    input  pc_W, ifid_W, idex_W, exmem_W, memwb_W,
           ifid_RST, idex_RST, exmem_RST, memwb_RST, halt,
           cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central sequencer for the five-stage pipeline. It resolves memory waits,
// HALT drain, EX redirects, load-use and fetch stalls in fixed priority.
// Controls are combinational from the state and inputs. The only stored
// state is the RUN/DRAIN/HALTED register and the saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  hazard_ctrl_if.master hif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, next_state;
  logic             mem_stall;
  logic             load_use;
  logic             inc_cycle;
  logic             inc_stall;
  logic             inc_flush;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  // Hazard detection. A write to $zero never creates a dependency.
  assign mem_stall = (hif.mem_dREN | hif.mem_dWEN) & ~hif.dhit;
  assign load_use  = hif.ex_dREN & hif.ex_WEN & (hif.ex_wsel != 5'd0) &
                     ((hif.id_use_rs & (hif.id_rsel1 == hif.ex_wsel)) |
                      (hif.id_use_rt & (hif.id_rsel2 == hif.ex_wsel)));

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Next-state and control decode, with priority inside RUN.
  // NOTE: every output gets a default before the case, which keeps this block free of inferred latches.
  always_comb begin
    next_state    = state;
    hif.pc_W      = 1'b0;
    hif.ifid_W    = 1'b0;
    hif.idex_W    = 1'b0;
    hif.exmem_W   = 1'b0;
    hif.memwb_W   = 1'b0;
    hif.ifid_RST  = 1'b0;
    hif.idex_RST  = 1'b0;
    hif.exmem_RST = 1'b0;
    hif.memwb_RST = 1'b0;
    hif.halt      = 1'b0;
    inc_cycle     = 1'b0;
    inc_stall     = 1'b0;
    inc_flush     = 1'b0;

    // While reset is held every control stays low, even though the state
    // register already reads RUN.
    if (nRST) begin
      unique case (state)
        RUN: begin
          inc_cycle = 1'b1;
          if (mem_stall) begin
            // Freeze the whole pipe and feed WB a bubble.
            hif.memwb_RST = 1'b1;
            inc_stall     = 1'b1;
          end else if (hif.mem_halt) begin
            // Let HALT move into WB and squash everything younger.
            hif.ifid_RST  = 1'b1;
            hif.idex_RST  = 1'b1;
            hif.exmem_RST = 1'b1;
            hif.memwb_W   = 1'b1;
            next_state    = DRAIN;
          end else if (hif.ex_redirect) begin
            // Take the new PC and drop the wrong-path IF and ID instructions.
            // Any in-flight fetch is abandoned, so ihit does not matter here.
            hif.pc_W     = 1'b1;
            hif.ifid_RST = 1'b1;
            hif.idex_RST = 1'b1;
            hif.exmem_W  = 1'b1;
            hif.memwb_W  = 1'b1;
            inc_flush    = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, and insert one bubble into EX.
            hif.idex_RST = 1'b1;
            hif.exmem_W  = 1'b1;
            hif.memwb_W  = 1'b1;
            inc_stall    = 1'b1;
          end else if (!hif.ihit) begin
            // The fetch is not done: hold PC and send a bubble into ID.
            hif.ifid_RST = 1'b1;
            hif.idex_W   = 1'b1;
            hif.exmem_W  = 1'b1;
            hif.memwb_W  = 1'b1;
            inc_stall    = 1'b1;
          end else begin
            hif.pc_W    = 1'b1;
            hif.ifid_W  = 1'b1;
            hif.idex_W  = 1'b1;
            hif.exmem_W = 1'b1;
            hif.memwb_W = 1'b1;
          end
        end
        DRAIN: begin
          // HALT retires in WB this cycle. The pipe behind it is already empty.
          inc_cycle     = 1'b1;
          hif.memwb_RST = 1'b1;
          next_state    = HALTED;
        end
        HALTED: begin
          hif.halt = 1'b1;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Saturating performance counters. They clear on reset and hold in HALTED.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (inc_cycle && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (inc_stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (inc_flush && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hif.cycle_cnt = cycle_q;
  assign hif.stall_cnt = stall_q;
  assign hif.flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a scoreboard. Two instances share the
// same stimulus: a 32-bit counter build and a 4-bit build for saturation.
// Each step pushes its hand-written expected controls and counters. A monitor
// on the falling edge pops them and compares against both instances.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.CNT_W(32)) hif();
  hazard_ctrl_if #(.CNT_W(4))  sif();

  hazard_ctrl #(.CNT_W(32)) dut     (.CLK(CLK), .nRST(nRST), .hif(hif));
  hazard_ctrl #(.CNT_W(4))  dut_sat (.CLK(CLK), .nRST(nRST), .hif(sif));

  assign sif.ihit        = hif.ihit;
  assign sif.dhit        = hif.dhit;
  assign sif.mem_dREN    = hif.mem_dREN;
  assign sif.mem_dWEN    = hif.mem_dWEN;
  assign sif.mem_halt    = hif.mem_halt;
  assign sif.ex_dREN     = hif.ex_dREN;
  assign sif.ex_WEN      = hif.ex_WEN;
  assign sif.ex_wsel     = hif.ex_wsel;
  assign sif.id_rsel1    = hif.id_rsel1;
  assign sif.id_rsel2    = hif.id_rsel2;
  assign sif.id_use_rs   = hif.id_use_rs;
  assign sif.id_use_rt   = hif.id_use_rt;
  assign sif.ex_redirect = hif.ex_redirect;

  typedef struct packed {
    logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_WEN;
    logic [4:0] ex_wsel, id_rsel1, id_rsel2;
    logic       id_use_rs, id_use_rt, ex_redirect;
  } in_t;

  // Control bits: {pc_W, ifid_W, idex_W, exmem_W, memwb_W,
  //                ifid_RST, idex_RST, exmem_RST, memwb_RST, halt}
  localparam logic [9:0] C_ZERO   = 10'b00000_0000_0;
  localparam logic [9:0] C_RUN    = 10'b11111_0000_0;
  localparam logic [9:0] C_MSTALL = 10'b00000_0001_0;
  localparam logic [9:0] C_HALT   = 10'b00001_1110_0;
  localparam logic [9:0] C_REDIR  = 10'b10011_1100_0;
  localparam logic [9:0] C_LU     = 10'b00011_0100_0;
  localparam logic [9:0] C_NOIHIT = 10'b00111_1000_0;
  localparam logic [9:0] C_DRAIN  = 10'b00000_0001_0;
  localparam logic [9:0] C_HALTED = 10'b00000_0000_1;

  // Counter effect of a cycle: cycle only, cycle+stall, cycle+flush, or none.
  typedef enum int {K_RUN, K_STALL, K_FLUSH, K_NONE} kind_t;

  typedef struct {
    string      name;
    logic [9:0] ctl;
    longint     cyc, stl, fl, scyc, sstl, sfl;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_cyc = 0, m_stl = 0, m_fl = 0, m_scyc = 0, m_sstl = 0, m_sfl = 0;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat_inc(input longint x, input longint max);
    return (x < max) ? x + 1 : x;
  endfunction

  function automatic in_t nop();
    in_t v;
    v      = '0;
    v.ihit = 1'b1;
    return v;
  endfunction

  task automatic apply(input in_t v);
    hif.ihit        = v.ihit;
    hif.dhit        = v.dhit;
    hif.mem_dREN    = v.mem_dREN;
    hif.mem_dWEN    = v.mem_dWEN;
    hif.mem_halt    = v.mem_halt;
    hif.ex_dREN     = v.ex_dREN;
    hif.ex_WEN      = v.ex_WEN;
    hif.ex_wsel     = v.ex_wsel;
    hif.id_rsel1    = v.id_rsel1;
    hif.id_rsel2    = v.id_rsel2;
    hif.id_use_rs   = v.id_use_rs;
    hif.id_use_rt   = v.id_use_rt;
    hif.ex_redirect = v.ex_redirect;
  endtask

  task automatic push(input string name, input logic [9:0] ctl);
    exp_t e;
    e.name = name; e.ctl = ctl;
    e.cyc  = m_cyc;  e.stl  = m_stl;  e.fl  = m_fl;
    e.scyc = m_scyc; e.sstl = m_sstl; e.sfl = m_sfl;
    sb.push_back(e);
  endtask

  // One clock of stimulus. The expected counter values are the ones before
  // this edge. The model then advances by the cycle's counter effect.
  task automatic step(input string name, input in_t v, input logic [9:0] ctl,
                      input kind_t k);
    apply(v);
    push(name, ctl);
    if (k != K_NONE) begin
      m_cyc  = sat_inc(m_cyc,  MAX32);
      m_scyc = sat_inc(m_scyc, MAX4);
    end
    if (k == K_STALL) begin
      m_stl  = sat_inc(m_stl,  MAX32);
      m_sstl = sat_inc(m_sstl, MAX4);
    end
    if (k == K_FLUSH) begin
      m_fl  = sat_inc(m_fl,  MAX32);
      m_sfl = sat_inc(m_sfl, MAX4);
    end
    @(posedge CLK); #1;
  endtask

  // Hold reset for one cycle with the current inputs left in place.
  task automatic reset_pulse(input string name);
    nRST = 1'b0;
    m_cyc = 0; m_stl = 0; m_fl = 0; m_scyc = 0; m_sstl = 0; m_sfl = 0;
    push(name, C_ZERO);
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  // Monitor: pop one expectation per falling edge and compare both builds.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, " ctl"}, longint'({hif.pc_W, hif.ifid_W, hif.idex_W, hif.exmem_W,
            hif.memwb_W, hif.ifid_RST, hif.idex_RST, hif.exmem_RST, hif.memwb_RST,
            hif.halt}), longint'(e.ctl));
      check({e.name, " sat ctl"}, longint'({sif.pc_W, sif.ifid_W, sif.idex_W, sif.exmem_W,
            sif.memwb_W, sif.ifid_RST, sif.idex_RST, sif.exmem_RST, sif.memwb_RST,
            sif.halt}), longint'(e.ctl));
      check({e.name, " cycle_cnt"},     longint'(hif.cycle_cnt), e.cyc);
      check({e.name, " stall_cnt"},     longint'(hif.stall_cnt), e.stl);
      check({e.name, " flush_cnt"},     longint'(hif.flush_cnt), e.fl);
      check({e.name, " sat cycle_cnt"}, longint'(sif.cycle_cnt), e.scyc);
      check({e.name, " sat stall_cnt"}, longint'(sif.stall_cnt), e.sstl);
      check({e.name, " sat flush_cnt"}, longint'(sif.flush_cnt), e.sfl);
    end
  end

  initial begin
    in_t v;
    apply(nop());
    @(posedge CLK); #1;

    // Reset state with a live HALT request on the inputs
    v = nop(); v.mem_halt = 1'b1;
    apply(v);
    reset_pulse("reset");

    // Clean stream
    for (int i = 0; i < 10; i++) step("clean", nop(), C_RUN, K_RUN);

    // Load-use through rt, then release after exactly one cycle
    v = nop(); v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 5; v.id_use_rt = 1; v.id_rsel2 = 5;
    step("lu_rt", v, C_LU, K_STALL);
    step("lu_release", nop(), C_RUN, K_RUN);
    // Load-use through rs
    v = nop(); v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 7; v.id_use_rs = 1; v.id_rsel1 = 7;
    step("lu_rs", v, C_LU, K_STALL);
    // The register matches, but the operand is not read
    v = nop(); v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 7; v.id_rsel2 = 7;
    step("lu_unused", v, C_RUN, K_RUN);
    // $zero destination never stalls
    v = nop(); v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 0; v.id_use_rt = 1; v.id_rsel2 = 0;
    v.id_use_rs = 1;
    step("lu_zero", v, C_RUN, K_RUN);
    // Not a load
    v = nop(); v.ex_WEN = 1; v.ex_wsel = 9; v.id_use_rs = 1; v.id_rsel1 = 9;
    step("lu_noload", v, C_RUN, K_RUN);

    // Memory wait: three cycles, then a normal advance
    v = nop(); v.mem_dREN = 1;
    for (int i = 0; i < 3; i++) step("mem_wait", v, C_MSTALL, K_STALL);
    v.dhit = 1;
    step("mem_done", v, C_RUN, K_RUN);
    v = nop(); v.mem_dWEN = 1; v.ihit = 0;
    step("mem_wr_wait", v, C_MSTALL, K_STALL);

    // A redirect held behind a memory stall, taken in the dhit cycle
    v = nop(); v.ex_redirect = 1; v.mem_dWEN = 1;
    for (int i = 0; i < 2; i++) step("redir_frozen", v, C_MSTALL, K_STALL);
    v.dhit = 1;
    step("redir_dhit", v, C_REDIR, K_FLUSH);
    // Redirect ignores ihit and beats load-use
    v = nop(); v.ex_redirect = 1; v.ihit = 0;
    v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 3; v.id_use_rs = 1; v.id_rsel1 = 3;
    step("redir_over_lu", v, C_REDIR, K_FLUSH);

    // Fetch miss, and load-use beating a fetch miss
    v = nop(); v.ihit = 0;
    step("no_ihit", v, C_NOIHIT, K_STALL);
    v.ex_dREN = 1; v.ex_WEN = 1; v.ex_wsel = 4; v.id_use_rt = 1; v.id_rsel2 = 4;
    step("lu_over_noihit", v, C_LU, K_STALL);

    // Reset in the middle of a memory stall
    v = nop(); v.mem_dREN = 1;
    step("stall_pre_rst", v, C_MSTALL, K_STALL);
    reset_pulse("rst_mid_stall");
    step("after_rst", nop(), C_RUN, K_RUN);

    // A memory stall beats HALT, then HALT beats redirect and drains
    v = nop(); v.mem_halt = 1; v.ex_redirect = 1; v.mem_dREN = 1;
    step("halt_frozen", v, C_MSTALL, K_STALL);
    v.dhit = 1;
    step("halt", v, C_HALT, K_RUN);
    v = nop(); v.ex_redirect = 1; v.ihit = 0;
    step("drain", v, C_DRAIN, K_RUN);
    step("halted", v, C_HALTED, K_NONE);
    v = nop(); v.mem_halt = 1; v.mem_dREN = 1;
    step("halted_hold", v, C_HALTED, K_NONE);
    step("halted_hold2", nop(), C_HALTED, K_NONE);
    reset_pulse("rst_halted");
    step("run_after_halt", nop(), C_RUN, K_RUN);

    // Saturation: 20 fetch-miss cycles from a fresh reset
    reset_pulse("rst_sat");
    v = nop(); v.ihit = 0;
    for (int i = 0; i < 20; i++) step("sat", v, C_NOIHIT, K_STALL);
    step("sat_held", nop(), C_RUN, K_RUN);
    step("sat_final", nop(), C_RUN, K_RUN);

    @(negedge CLK); #1;
    check("scoreboard drained", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
